hazard_stall_unit: RTL and testbench

Generates the Hazard_o control that drives the ID-stage control bubble mux, plus the PC and IF/ID write enables and the IF flush.
- Detects load-use, ALU-to-branch and load-to-branch hazards in ID.
- Holds the stall for a parameterised number of cycles using a small FSM, because the producing instruction has left EX after the first bubble.
- Optionally keeps saturating stall/flush statistics counters.

---
 rtl/hazard_stall_unit.sv | 118 +++++++++++
 tb/tb_hazard_stall_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection with a multi-cycle stall FSM, bubble/enable/flush control.
// Optional saturating stall/flush statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_stall_unit #(
    parameter int unsigned LOAD_USE_STALL    = 1,
    parameter int unsigned LOAD_BRANCH_STALL = 2,
    parameter int unsigned ALU_BRANCH_STALL  = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic             IDEX_RegWrite_i,
    input  logic [4:0]       IDEX_WrReg_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             IFID_UsesRt_i,
    input  logic             IFID_Branch_i,
    input  logic             BranchTaken_i,
    input  logic             Jump_i,
    output logic             Hazard_o,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFFlush_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
);

    typedef enum logic {RUN, STALL} state_t;

    // Remaining bubbles after the first one, loaded into the down-counter.
    localparam logic [1:0] LU_REM = 2'(LOAD_USE_STALL - 1);
    localparam logic [1:0] LB_REM = 2'(LOAD_BRANCH_STALL - 1);
    localparam logic [1:0] AB_REM = 2'(ALU_BRANCH_STALL - 1);

    state_t     state, state_nxt;
    logic [1:0] rem, rem_nxt;
    logic [1:0] hz_rem;
    logic       match, hz_lb, hz_lu, hz_ab, any_hz;
    logic       stalled;

    // $zero never carries a dependency, so a zero destination cannot match.
    assign match = (IDEX_WrReg_i != 5'd0) &&
                   ((IDEX_WrReg_i == IFID_Rs_i) ||
                    (IFID_UsesRt_i && (IDEX_WrReg_i == IFID_Rt_i)));

    assign hz_lb  = IDEX_MemRead_i && match && IFID_Branch_i;
    assign hz_lu  = IDEX_MemRead_i && match && !IFID_Branch_i;
    assign hz_ab  = IDEX_RegWrite_i && !IDEX_MemRead_i && match && IFID_Branch_i;
    assign any_hz = hz_lb || hz_lu || hz_ab;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        hz_rem = 2'd0;
        if (hz_lb)      hz_rem = LB_REM;
        else if (hz_lu) hz_rem = LU_REM;
        else if (hz_ab) hz_rem = AB_REM;
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        case (state)
            RUN: begin
                if (any_hz) begin
                    rem_nxt   = hz_rem;
                    state_nxt = (hz_rem != 2'd0) ? STALL : RUN;
                end
            end
            STALL: begin
                rem_nxt = rem - 2'd1;
                if (rem <= 2'd1) state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                rem_nxt   = 2'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
            rem   <= 2'd0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Outputs are gated by reset so an asserted reset aborts a stall in the same cycle.
    assign stalled     = rst_i && ((state == STALL) || any_hz);
    assign Hazard_o    = stalled;
    assign PCWrite_o   = !stalled;
    assign IFIDWrite_o = !stalled;
    assign IFFlush_o   = rst_i && (BranchTaken_i || Jump_i) && !stalled;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (Hazard_o && (stall_cnt != '1))   stall_cnt <= stall_cnt + CNT_W'(1);
            if (IFFlush_o && (flush_cnt != '1))  flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign StallCnt_o = stall_cnt;
    assign FlushCnt_o = flush_cnt;
`else
    assign StallCnt_o = '0;
    assign FlushCnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: a driver queues expected outputs per cycle,
// a monitor on the falling edge pops and compares. Two instances cover LOAD_BRANCH_STALL=2/3.
module tb_hazard_stall_unit;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       IDEX_MemRead_i = 1'b0, IDEX_RegWrite_i = 1'b0;
    logic [4:0] IDEX_WrReg_i = '0, IFID_Rs_i = '0, IFID_Rt_i = '0;
    logic       IFID_UsesRt_i = 1'b0, IFID_Branch_i = 1'b0, BranchTaken_i = 1'b0, Jump_i = 1'b0;

    logic        hz0, pcw0, ifw0, fl0;
    logic [15:0] sc0, fc0;
    logic        hz3, pcw3, ifw3, fl3;
    logic [1:0]  sc3, fc3;

    always #5 clk_i = ~clk_i;

    hazard_stall_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RegWrite_i(IDEX_RegWrite_i),
        .IDEX_WrReg_i(IDEX_WrReg_i), .IFID_Rs_i(IFID_Rs_i), .IFID_Rt_i(IFID_Rt_i),
        .IFID_UsesRt_i(IFID_UsesRt_i), .IFID_Branch_i(IFID_Branch_i),
        .BranchTaken_i(BranchTaken_i), .Jump_i(Jump_i),
        .Hazard_o(hz0), .PCWrite_o(pcw0), .IFIDWrite_o(ifw0), .IFFlush_o(fl0),
        .StallCnt_o(sc0), .FlushCnt_o(fc0)
    );

    hazard_stall_unit #(.LOAD_BRANCH_STALL(3), .CNT_W(2)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RegWrite_i(IDEX_RegWrite_i),
        .IDEX_WrReg_i(IDEX_WrReg_i), .IFID_Rs_i(IFID_Rs_i), .IFID_Rt_i(IFID_Rt_i),
        .IFID_UsesRt_i(IFID_UsesRt_i), .IFID_Branch_i(IFID_Branch_i),
        .BranchTaken_i(BranchTaken_i), .Jump_i(Jump_i),
        .Hazard_o(hz3), .PCWrite_o(pcw3), .IFIDWrite_o(ifw3), .IFFlush_o(fl3),
        .StallCnt_o(sc3), .FlushCnt_o(fc3)
    );

    typedef struct {
        string name;
        bit    sel3;
        bit    hz;
        bit    fl;
        bit    cnt_chk;
        int    sc16, fc16, sc2, fc2;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit   cur_sel = 1'b0;
    bit   cnt_chk = 1'b0;
    int   e_sc16 = 0, e_fc16 = 0, e_sc2 = 0, e_fc2 = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock cycle of stimulus plus its expected hazard/flush outputs.
    task automatic cyc(input string name, input bit rst, input bit mr, input bit rw,
                       input int wr, input int rs, input int rt, input bit ut,
                       input bit br, input bit bt, input bit jp,
                       input bit e_hz, input bit e_fl);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i           = rst;
        IDEX_MemRead_i  = mr;
        IDEX_RegWrite_i = rw;
        IDEX_WrReg_i    = 5'(wr);
        IFID_Rs_i       = 5'(rs);
        IFID_Rt_i       = 5'(rt);
        IFID_UsesRt_i   = ut;
        IFID_Branch_i   = br;
        BranchTaken_i   = bt;
        Jump_i          = jp;
        e.name    = name;
        e.sel3    = cur_sel;
        e.hz      = e_hz;
        e.fl      = e_fl;
        e.cnt_chk = cnt_chk;
        e.sc16    = STATS ? e_sc16 : 0;
        e.fc16    = STATS ? e_fc16 : 0;
        e.sc2     = STATS ? e_sc2  : 0;
        e.fc2     = STATS ? e_fc2  : 0;
        sb_q.push_back(e);
        cnt_chk = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".Hazard"},   int'(e.sel3 ? hz3  : hz0),  int'(e.hz));
                check({e.name, ".PCWrite"},  int'(e.sel3 ? pcw3 : pcw0), int'(!e.hz));
                check({e.name, ".IFIDWrite"},int'(e.sel3 ? ifw3 : ifw0), int'(!e.hz));
                check({e.name, ".IFFlush"},  int'(e.sel3 ? fl3  : fl0),  int'(e.fl));
                if (e.cnt_chk) begin
                    check({e.name, ".StallCnt16"}, int'(sc0), e.sc16);
                    check({e.name, ".FlushCnt16"}, int'(fc0), e.fc16);
                    check({e.name, ".StallCnt2"},  int'(sc3), e.sc2);
                    check({e.name, ".FlushCnt2"},  int'(fc3), e.fc2);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        //   name               rst mr rw wr rs rt ut br bt jp  hz fl
        cyc("reset_jump",       0,  0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0);
        cyc("reset_release",    1,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0);
        // Load-use: one bubble, then resume with the bubble in EX.
        cyc("lu_bubble",        1,  1, 1, 2, 2, 0, 0, 0, 0, 0,  1, 0);
        cyc("lu_resume",        1,  0, 0, 0, 2, 0, 0, 0, 0, 0,  0, 0);
        // Load-branch: two bubbles, taken flag ignored while stalled, then flush.
        cyc("lb_bubble1",       1,  1, 1, 5, 5, 0, 0, 1, 1, 0,  1, 0);
        cyc("lb_bubble2",       1,  0, 0, 0, 5, 0, 0, 1, 1, 0,  1, 0);
        cyc("lb_taken_flush",   1,  0, 0, 0, 5, 0, 0, 1, 1, 0,  0, 1);
        cyc("idle_a",           1,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0);
        // ALU-branch via rt: one bubble; $zero destination never stalls.
        cyc("ab_bubble",        1,  0, 1, 3, 1, 3, 1, 1, 0, 0,  1, 0);
        cyc("ab_resume",        1,  0, 0, 0, 1, 3, 1, 1, 0, 0,  0, 0);
        cyc("zero_dest_alu",    1,  0, 1, 0, 0, 0, 1, 1, 0, 0,  0, 0);
        cyc("zero_dest_load",   1,  1, 1, 0, 0, 0, 1, 0, 0, 0,  0, 0);
        // rt not used: no stall, jump flushes with enables high.
        cyc("rt_unused_jump",   1,  1, 1, 4, 1, 4, 0, 0, 0, 1,  0, 1);
        cyc("lu_rt_bubble",     1,  1, 1, 7, 1, 7, 1, 0, 0, 0,  1, 0);
        cyc("lu_rt_resume",     1,  0, 0, 0, 1, 7, 1, 0, 0, 0,  0, 0);
        cyc("alu_no_branch",    1,  0, 1, 6, 6, 0, 0, 0, 0, 0,  0, 0);

        // LOAD_BRANCH_STALL=3 instance: reset lands in the second bubble cycle.
        cur_sel = 1'b1;
        cyc("lb3_bubble1",      1,  1, 1, 5, 5, 0, 0, 1, 0, 0,  1, 0);
        cyc("lb3_bubble2",      1,  0, 0, 0, 5, 0, 0, 1, 0, 0,  1, 0);
        @(negedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc("lb3_in_reset",     0,  0, 0, 0, 5, 0, 0, 1, 0, 0,  0, 0);
        cyc("lb3_released",     1,  0, 0, 0, 5, 0, 0, 1, 0, 0,  0, 0);

        // Statistics from reset: five single-cycle stalls and two flushes.
        cyc("st_h1",            1,  1, 1, 2, 2, 0, 0, 0, 0, 0,  1, 0);
        cyc("st_h2",            1,  0, 1, 3, 1, 3, 1, 1, 0, 0,  1, 0);
        cyc("st_h3",            1,  1, 1, 2, 2, 0, 0, 0, 0, 0,  1, 0);
        cnt_chk = 1'b1; e_sc16 = 3; e_fc16 = 0; e_sc2 = 3; e_fc2 = 0;
        cyc("st_h4",            1,  0, 1, 3, 1, 3, 1, 1, 0, 0,  1, 0);
        cyc("st_h5",            1,  1, 1, 2, 2, 0, 0, 0, 0, 0,  1, 0);
        cyc("st_f1",            1,  0, 0, 0, 1, 0, 0, 0, 0, 1,  0, 1);
        cyc("st_f2",            1,  0, 0, 0, 9, 0, 0, 1, 1, 0,  0, 1);
        cnt_chk = 1'b1; e_sc16 = 5; e_fc16 = 2; e_sc2 = 3; e_fc2 = 2;
        cyc("st_final",         1,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk_i);
        @(posedge clk_i);
        if (sb_q.size() > 0) check("scoreboard_drain", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
